// File: rtl/bit_packer_pkg.sv
// Shared types and default geometry for the bit packer.
package bit_pack_pkg;

    localparam int unsigned DEF_ACC_W = 128;
    localparam int unsigned DEF_IN_W  = 64;
    localparam int unsigned DEF_OUT_W = 32;
    localparam int unsigned FILL_W    = 8;
    localparam int unsigned AMT_W     = 7;

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

endpackage

// File: rtl/bit_packer_shifter.sv
// Zero-filling logarithmic left shifter: seven stages of 1/2/4/../64.
module barrel_shifter_left #(
    parameter int unsigned WIDTH = 128
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [6:0]       i_amt,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_stage [0:7];

    assign w_stage[0] = i_data;

    for (genvar k = 0; k < 7; k++) begin : g_stage
        assign w_stage[k+1] = i_amt[k] ? (w_stage[k] << (2 ** k)) : w_stage[k];
    end

    assign o_data = w_stage[7];

endmodule

// File: rtl/bit_packer.sv
// MSB-first variable-length codeword packer emitting fixed OUT_W words.
// Optional BIT_PACKER_STATS_EN adds a saturating accepted-bit counter.
module bit_packer
    import bit_pack_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [IN_W-1:0]  i_data,
    input  logic [6:0]       i_len,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_data,
    output logic             o_flush_done
`ifdef BIT_PACKER_STATS_EN
    ,
    output logic [31:0]      o_bit_count
`endif
);

    logic [ACC_W-1:0]  r_acc;
    logic [FILL_W-1:0] r_fill;
    state_t            r_state;
    state_t            w_state_nxt;

    logic [6:0]        w_len_eff;
    logic [IN_W-1:0]   w_mask;
    logic [IN_W-1:0]   w_masked;
    logic [ACC_W-1:0]  w_ins;
    logic [ACC_W-1:0]  w_shifted;
    logic [ACC_W-1:0]  w_acc_b;
    logic [FILL_W-1:0] w_fill_b;
    logic [AMT_W-1:0]  w_amt;
    logic              w_pad;
    logic              w_pop;
    logic              w_push;

    always_comb begin
        w_len_eff = i_len;
        if (i_len > 7'(IN_W)) begin
            w_len_eff = 7'(IN_W);
        end
        w_mask = '1;
        if (w_len_eff < 7'(IN_W)) begin
            w_mask = (IN_W'(1) << w_len_eff) - IN_W'(1);
        end
        w_masked = i_data & w_mask;
        w_ins    = ACC_W'(w_masked);
    end

    // Pad only exists while flushing a partial word; it is what forces the last pop.
    assign w_pad   = (r_state == S_FLUSH) && (r_fill != '0) && (r_fill < FILL_W'(OUT_W));
    assign o_valid = (r_fill >= FILL_W'(OUT_W)) || w_pad;
    assign o_data  = r_acc[ACC_W-1 -: OUT_W];
    assign o_ready = (r_state == S_RUN) && (r_fill <= FILL_W'(ACC_W - IN_W));
    assign o_flush_done = (r_state == S_DONE);

    assign w_pop  = o_valid && i_ready;
    assign w_push = i_valid && o_ready && (w_len_eff != '0);

    always_comb begin
        w_acc_b  = r_acc;
        w_fill_b = r_fill;
        if (w_pop) begin
            w_acc_b  = r_acc << OUT_W;
            w_fill_b = r_fill - FILL_W'(OUT_W);
        end
    end

    // Append position is taken after the pop, so pop+append in one cycle is seamless.
    assign w_amt = AMT_W'(ACC_W - 32'(w_fill_b) - 32'(w_len_eff));

    barrel_shifter_left #(
        .WIDTH (ACC_W)
    ) u_shift (
        .i_data (w_ins),
        .i_amt  (w_amt),
        .o_data (w_shifted)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (w_pop && w_pad) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (w_push) begin
            r_acc  <= w_acc_b | w_shifted;
            r_fill <= w_fill_b + FILL_W'(w_len_eff);
        end else begin
            r_acc  <= w_acc_b;
            r_fill <= w_fill_b;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (i_flush) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_fill == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

`ifdef BIT_PACKER_STATS_EN
    logic [31:0] r_bit_count;
    logic [32:0] w_cnt_sum;

    assign w_cnt_sum   = {1'b0, r_bit_count} + 33'(w_len_eff);
    assign o_bit_count = r_bit_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || (r_state == S_DONE)) begin
            r_bit_count <= '0;
        end else if (w_push) begin
            r_bit_count <= w_cnt_sum[32] ? '1 : w_cnt_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_bit_packer.sv
// Scoreboard bench for bit_packer: bit-queue reference model, decoupled monitor.
module tb_bit_packer;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_data;
    logic [6:0]  i_len;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_flush_done;
`ifdef BIT_PACKER_STATS_EN
    logic [31:0] o_bit_count;
`endif

    always #5 clk = ~clk;

    bit_packer #(
        .ACC_W (128),
        .IN_W  (64),
        .OUT_W (32)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .i_len        (i_len),
        .i_flush      (i_flush),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_flush_done (o_flush_done)
`ifdef BIT_PACKER_STATS_EN
        ,
        .o_bit_count  (o_bit_count)
`endif
    );

    bit          model_bits[$];
    logic [31:0] exp_q[$];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic        last_ready;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    function automatic void model_push(logic [6:0] len, logic [63:0] d);
        int          le;
        logic [31:0] w;
        le = (len > 7'd64) ? 64 : int'(len);
        for (int i = le - 1; i >= 0; i--) model_bits.push_back(d[i]);
        while (model_bits.size() >= 32) begin
            for (int j = 31; j >= 0; j--) w[j] = model_bits.pop_front();
            exp_q.push_back(w);
        end
    endfunction

    function automatic void model_flush();
        logic [31:0] w;
        if (model_bits.size() > 0) begin
            w = '0;
            for (int j = 31; j >= 0; j--) begin
                if (model_bits.size() > 0) w[j] = model_bits.pop_front();
            end
            exp_q.push_back(w);
        end
    endfunction

    task automatic cyc(input logic v, input logic [6:0] len, input logic [63:0] d,
                       input logic fl, input logic rdy);
        @(negedge clk);
        i_valid = v;
        i_len   = len;
        i_data  = d;
        i_flush = fl;
        i_ready = rdy;
        #1;
        last_ready = o_ready;
        if (v && o_ready) model_push(len, d);
        if (fl) model_flush();
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            cyc(1'b0, 7'd0, 64'd0, 1'b0, 1'($urandom_range(0, 1)));
            seen = o_flush_done;
        end
        chk("flush_done", 64'(seen), 64'd1);
        chk("flush_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compares every handshaken word and checks hold stability under backpressure.
    logic        held = 1'b0;
    logic [31:0] held_data;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!i_rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", 64'(o_valid), 64'd1);
                    chk("hold_data", 64'(o_data), 64'(held_data));
                end
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 64'(o_data), 64'hXXXX_XXXX_XXXX_XXXX);
                    end else begin
                        chk("word", 64'(o_data), 64'(exp_q.pop_front()));
                    end
                    held = 1'b0;
                end else if (o_valid) begin
                    held      = 1'b1;
                    held_data = o_data;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_len   = '0;
        i_data  = '0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_done", 64'(o_flush_done), 64'd0);
        i_rst_n = 1'b1;

        // Flush when empty: done pulses two cycles after the request.
        cyc(1'b0, 7'd0, 64'd0, 1'b1, 1'b1);
        cyc(1'b0, 7'd0, 64'd0, 1'b0, 1'b1);
        chk("empty_flush_t1", 64'(o_flush_done), 64'd0);
        cyc(1'b0, 7'd0, 64'd0, 1'b0, 1'b1);
        chk("empty_flush_t2", 64'(o_flush_done), 64'd1);
        cyc(1'b0, 7'd0, 64'd0, 1'b0, 1'b1);
        chk("empty_flush_t3", 64'(o_flush_done), 64'd0);

        // Basic packing, then fill must return to empty.
        repeat (4) cyc(1'b1, 7'd8, 64'hFFFF_0000_0000_00A5, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 7'd0, 64'd0, 1'b0, 1'b1);
        chk("basic_empty", 64'(o_valid), 64'd0);

        // Straddle: 8 bits stay pending, then flush pads them out.
        cyc(1'b1, 7'd20, 64'h0000_0000_000A_BCDE, 1'b0, 1'b1);
        cyc(1'b1, 7'd20, 64'h0000_0000_0001_2345, 1'b0, 1'b1);
        cyc(1'b0, 7'd0, 64'd0, 1'b1, 1'b1);
        wait_done();

        // Flush with pad, then next codeword starts at MSB.
        cyc(1'b1, 7'd5, 64'h0000_0000_0000_0016, 1'b0, 1'b1);
        cyc(1'b0, 7'd0, 64'd0, 1'b1, 1'b1);
        wait_done();
        repeat (4) cyc(1'b1, 7'd8, 64'h0000_0000_0000_00C3, 1'b0, 1'b1);

        // Edge lengths: 0 is a no-op, 100 clamps to 64.
        cyc(1'b1, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        cyc(1'b1, 7'd100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 7'd0, 64'd0, 1'b0, 1'b1);
        chk("len100_empty", 64'(o_valid), 64'd0);

        // Simultaneous pop and append at full rate.
        for (int n = 0; n < 8; n++) cyc(1'b1, 7'd32, {$urandom, $urandom}, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, 7'd0, 64'd0, 1'b0, 1'b1);

        // Backpressure: ready drops once fill exceeds 64.
        cyc(1'b1, 7'd64, {$urandom, $urandom}, 1'b0, 1'b0);
        chk("bp_ready1", 64'(last_ready), 64'd1);
        cyc(1'b1, 7'd64, {$urandom, $urandom}, 1'b0, 1'b0);
        chk("bp_ready2", 64'(last_ready), 64'd1);
        cyc(1'b1, 7'd64, {$urandom, $urandom}, 1'b0, 1'b0);
        chk("bp_ready_low", 64'(last_ready), 64'd0);
        repeat (4) cyc(1'b1, 7'd64, {$urandom, $urandom}, 1'b0, 1'b0);
        repeat (6) cyc(1'b0, 7'd0, 64'd0, 1'b0, 1'b1);
        chk("bp_empty", 64'(o_valid), 64'd0);

        // Reset in the middle of a flush with fill = 40.
        cyc(1'b1, 7'd40, {$urandom, $urandom}, 1'b0, 1'b0);
        cyc(1'b0, 7'd0, 64'd0, 1'b1, 1'b0);
        cyc(1'b0, 7'd0, 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        i_rst_n = 1'b0;
        exp_q.delete();
        model_bits.delete();
        @(negedge clk);
        #1;
        chk("midrst_valid", 64'(o_valid), 64'd0);
        chk("midrst_ready", 64'(o_ready), 64'd1);
        chk("midrst_done", 64'(o_flush_done), 64'd0);
        i_rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cyc(1'b0, 7'd0, 64'd0, 1'b0, 1'b1);
            chk("midrst_no_done", 64'(o_flush_done), 64'd0);
        end

        // Randomized traffic with periodic flushes.
        for (int c = 0; c < 2500; c++) begin
            logic       v, fl, rdy;
            logic [6:0] len;
            v   = ($urandom_range(0, 9) < 7);
            len = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(65, 127))
                                               : 7'($urandom_range(0, 64));
            rdy = ($urandom_range(0, 9) < 7);
            fl  = ((c % 300) == 299);
            cyc(v, len, {$urandom, $urandom}, fl, rdy);
            if (fl) wait_done();
        end
        cyc(1'b0, 7'd0, 64'd0, 1'b1, 1'b1);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
